// File: rtl/iter_sll.sv
// iter_sll: iterative logical-left shifter.
//
// Shifts the captured operand one bit toward the MSB per clock, zero-filling
// the LSB, until the requested amount has been applied. Used for SLL/SLLV
// when the single-cycle barrel shifter is not present.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous, active-high reset
//   start  - shift request, only accepted while ready=1
//   num    - operand, captured on an accepted start
//   shamt  - shift amount 0..WIDTH-1, captured on an accepted start
//   ready  - unit can accept a start (idle or completing)
//   busy   - shift in progress
//   done   - one-cycle pulse, result/cout freshly updated
//   result - num << shamt, registered, held until the next completion
//   cout   - last bit shifted out of the MSB (0 when shamt=0)
module iter_sll #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [SHW-1:0]   shamt,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;

    // Handshake outputs are pure state decodes, so nothing on the input side
    // can reach them combinationally.
    assign ready = (state == StIdle) || (state == StDone);
    assign busy  = (state == StShift);
    assign done  = (state == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            work   <= '0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                // DONE accepts a new request exactly like IDLE so that
                // back-to-back operations run without a bubble.
                StIdle, StDone: begin
                    if (start) begin
                        work <= num;
                        cnt  <= shamt;
                        if (shamt == '0) begin
                            state  <= StDone;
                            result <= num;
                            cout   <= 1'b0;
                        end else begin
                            state <= StShift;
                        end
                    end else begin
                        state <= StIdle;
                    end
                end

                // cnt counts the shifts still owed; cnt==1 marks the final
                // one, so the shifted value is published directly into result
                // rather than waiting another cycle for work to settle.
                StShift: begin
                    work <= {work[WIDTH-2:0], 1'b0};
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        state  <= StDone;
                        result <= {work[WIDTH-2:0], 1'b0};
                        cout   <= work[WIDTH-1];
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule
